// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: datapath widths, add/sub opcodes,
// functional-unit state encoding and the CDB payload type.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    FU_IDLE     = 2'd0,
    FU_EXEC     = 2'd1,
    FU_WAIT_CDB = 2'd2
  } fu_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/asfu_alu.sv
// Combinational add/subtract core of the ASFU; modulo-2^DW arithmetic.
// Signed-overflow flag is present only when ASFU_OVF_EN is defined.
module asfu_alu
  import tomasulo_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
`ifdef ASFU_OVF_EN
  output logic          ovf,
`endif
  output logic [DW-1:0] result
);

  logic signed [DW-1:0] a_s;
  logic signed [DW-1:0] b_s;
  logic signed [DW-1:0] r_s;

  assign a_s = $signed(a);
  assign b_s = $signed(b);

  always_comb begin
    r_s = '0;
    case (op)
      OP_ADD:  r_s = a_s + b_s;
      OP_SUB:  r_s = a_s - b_s;
      default: r_s = '0;
    endcase
  end

  assign result = $unsigned(r_s);

`ifdef ASFU_OVF_EN
  // Overflow: result sign disagrees with what the operand signs allow.
  always_comb begin
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = (a_s[DW-1] == b_s[DW-1]) && (r_s[DW-1] != a_s[DW-1]);
      OP_SUB:  ovf = (a_s[DW-1] != b_s[DW-1]) && (r_s[DW-1] != a_s[DW-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/asfu.sv
// Add/subtract functional unit fed by the ASRS: latches one instruction,
// executes for LATENCY cycles, then holds its tagged result on the CDB until
// granted. Optional ovf output under ASFU_OVF_EN.
module asfu
  import tomasulo_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DW      = DATA_W,
  parameter int TW      = TAG_W
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          start,
  output logic          ready,
  input  logic [DW-1:0] Vj,
  input  logic [DW-1:0] Vk,
  input  logic [2:0]    OPcode,
  input  logic [TW-1:0] tag_in,
  output logic          busy,
  output logic          cdb_req,
  input  logic          cdb_grant,
`ifdef ASFU_OVF_EN
  output logic          ovf,
`endif
  output logic [DW-1:0] CDB,
  output logic [TW-1:0] cdb_tag
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  fu_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] vj_q, vk_q, res_q;
  logic [2:0]    op_q;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] alu_res;
  logic          accept, done;

`ifdef ASFU_OVF_EN
  logic alu_ovf;
  logic ovf_q;
`endif

  asfu_alu #(.DW(DW)) u_alu (
    .a      (vj_q),
    .b      (vk_q),
    .op     (op_q),
`ifdef ASFU_OVF_EN
    .ovf    (alu_ovf),
`endif
    .result (alu_res)
  );

  assign accept = (state_q == FU_IDLE) && start;
  assign done   = (state_q == FU_EXEC) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FU_IDLE: begin
        if (start) begin
          state_d = FU_EXEC;
          cnt_d   = CNT_INIT;
        end
      end
      FU_EXEC: begin
        if (cnt_q == 4'd0) state_d = FU_WAIT_CDB;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FU_WAIT_CDB: begin
        if (cdb_grant) state_d = FU_IDLE;
      end
      default: state_d = FU_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= FU_IDLE;
      cnt_q   <= '0;
      vj_q    <= '0;
      vk_q    <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      res_q   <= '0;
`ifdef ASFU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        vj_q  <= Vj;
        vk_q  <= Vk;
        op_q  <= OPcode;
        tag_q <= tag_in;
      end
      if (done) begin
        res_q <= alu_res;
`ifdef ASFU_OVF_EN
        ovf_q <= alu_ovf;
`endif
      end
    end
  end

  // Bus outputs are forced to zero outside WAIT_CDB so they can be OR-merged.
  assign ready   = (state_q == FU_IDLE);
  assign busy    = (state_q != FU_IDLE);
  assign cdb_req = (state_q == FU_WAIT_CDB);
  assign CDB     = cdb_req ? res_q : '0;
  assign cdb_tag = cdb_req ? tag_q : '0;
`ifdef ASFU_OVF_EN
  assign ovf     = cdb_req & ovf_q;
`endif

endmodule

// File: tb/tb_asfu.sv
// Self-checking bench for asfu: directed cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_asfu;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        start;
  logic        ready;
  logic [15:0] Vj, Vk;
  logic [2:0]  OPcode;
  logic [2:0]  tag_in;
  logic        busy;
  logic        cdb_req;
  logic        cdb_grant;
  logic [15:0] CDB;
  logic [2:0]  cdb_tag;
`ifdef ASFU_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  asfu #(.LATENCY(LAT), .DW(16), .TW(3)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start),
    .ready     (ready),
    .Vj        (Vj),
    .Vk        (Vk),
    .OPcode    (OPcode),
    .tag_in    (tag_in),
    .busy      (busy),
    .cdb_req   (cdb_req),
    .cdb_grant (cdb_grant),
`ifdef ASFU_OVF_EN
    .ovf       (ovf),
`endif
    .CDB       (CDB),
    .cdb_tag   (cdb_tag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: integer arithmetic reduced modulo 2^16; unknown opcodes yield 0.
  function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    int s;
    if (op == 3'd0)      s = int'(a) + int'(b);
    else if (op == 3'd1) s = int'(a) - int'(b);
    else                 s = 0;
    return 16'(s);
  endfunction

  // Reference: overflow when the exact signed result leaves the 16-bit range.
  function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] op);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 3'd0)      s = sa + sb;
    else if (op == 3'd1) s = sa - sb;
    else                 return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, cdb_req, 0);
    chk({tag, "_cdb"}, CDB, 0);
    chk({tag, "_tag"}, cdb_tag, 0);
`ifdef ASFU_OVF_EN
    chk({tag, "_ovf"}, ovf, 0);
`endif
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic [2:0] tg, input int hold);
    logic [15:0] er;
    er = model_res(a, b, op);
    chk("ready_before", ready, 1);
    Vj = a; Vk = b; OPcode = op; tag_in = tg; start = 1'b1;
    step();
    start = 1'b0;
    Vj = 16'($urandom); Vk = 16'($urandom); OPcode = 3'($urandom); tag_in = 3'($urandom);
    chk("busy_exec", busy, 1);
    chk("ready_exec", ready, 0);
    for (int i = 0; i < LAT; i++) begin
      chk("req_early", cdb_req, 0);
      cdb_grant = 1'($urandom_range(0, 1));
      step();
    end
    cdb_grant = 1'b0;
    chk("req_on_time", cdb_req, 1);
    chk("cdb_data", CDB, er);
    chk("cdb_tag", cdb_tag, tg);
`ifdef ASFU_OVF_EN
    chk("ovf", ovf, model_ovf(a, b, op));
`endif
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      Vj = 16'($urandom); Vk = 16'($urandom); tag_in = 3'($urandom);
      step();
      chk("hold_req", cdb_req, 1);
      chk("hold_cdb", CDB, er);
      chk("hold_tag", cdb_tag, tg);
      chk("hold_ready", ready, 0);
    end
    start = 1'b1;
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    start = 1'b0;
    check_idle("after_grant");
  endtask

  initial begin
    CLR = 1'b1; start = 1'b0; cdb_grant = 1'b0;
    Vj = '0; Vk = '0; OPcode = '0; tag_in = '0;
    #1;
    check_idle("reset_async");
    step();
    step();
    check_idle("reset_held");
    CLR = 1'b0;
    step();
    check_idle("post_reset");

    run_op(16'd5, 16'd3, 3'b000, 3'd2, 0);
    run_op(16'h0003, 16'h0005, 3'b001, 3'd1, 0);
    run_op(16'h1234, 16'h0101, 3'b000, 3'd5, 5);
    run_op(16'h00AA, 16'h0055, 3'b111, 3'd4, 1);
    run_op(16'h7FFF, 16'h0001, 3'b000, 3'd3, 0);
    run_op(16'h8000, 16'h0001, 3'b001, 3'd6, 0);
    run_op(16'hFFFF, 16'hFFFF, 3'b000, 3'd7, 2);

    // Reset in the middle of execution must drop the instruction silently.
    Vj = 16'd10; Vk = 16'd20; OPcode = 3'b000; tag_in = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_pre_busy", busy, 1);
    #2 CLR = 1'b1;
    #1;
    check_idle("clr_mid_exec");
    step();
    CLR = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("clr_no_bcast", cdb_req, 0);
    end

    for (int n = 0; n < 20; n++) begin
      logic [2:0] op;
      op = (($urandom_range(0, 3)) == 3) ? 3'($urandom) : 3'($urandom_range(0, 1));
      run_op(16'($urandom), 16'($urandom), op, 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asfu.md
Name: asfu

Overview:
- Add/subtract functional unit directly downstream of the add/sub reservation station (ASRS) in the Tomasulo core.
- Accepts one ready instruction from the reservation station: operands Vj/Vk, opcode and the station's tag.
- Executes over a parameterised latency, then holds the result and requests the Common Data Bus (CDB).
- Broadcasts result plus tag when granted, so waiting stations and the register status table can capture it.

Parameters:
- LATENCY, 2, execute cycles between the accept edge and CDB request; legal range 1..15.
- DW, 16, operand/result width.
- TW, 3, tag width; the tag identifies the producing reservation station.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- start  in  1  issue valid from reservation station; Vj/Vk/OPcode/tag_in are valid while high.
- ready  out  1  unit can accept; high exactly when state is IDLE.
- Vj  in  DW  first operand.
- Vk  in  DW  second operand.
- OPcode  in  3  operation select.
- tag_in  in  TW  tag of the issuing reservation station.
- busy  out  1  high whenever state is not IDLE.
- cdb_req  out  1  result valid, requesting the CDB.
- cdb_grant  in  1  arbiter grant, sampled on CLK.
- CDB  out  DW  result; 0 when cdb_req is low, so it can be OR-merged onto the bus.
- cdb_tag  out  TW  tag of the result; 0 when cdb_req is low.

Behaviour:
- Reset (async, CLR=1): state IDLE, internal counter 0, operand/tag/opcode registers 0.
  - Outputs during and after reset: ready=1, busy=0, cdb_req=0, CDB=0, cdb_tag=0.
  - CLR mid-operation discards the in-flight instruction; nothing is broadcast.
- FSM states: IDLE, EXEC, WAIT_CDB.
- IDLE:
  - Accept on a rising edge with start=1: latch Vj, Vk, OPcode, tag_in; load cnt=LATENCY-1; go to EXEC.
  - start=0: stay in IDLE.
- EXEC:
  - Each edge with cnt!=0 decrements cnt.
  - Edge with cnt==0: register the result, go to WAIT_CDB.
  - Net effect: cdb_req rises LATENCY edges after the accept edge.
- WAIT_CDB:
  - cdb_req=1; CDB and cdb_tag are stable registered values.
  - Edge with cdb_grant=1: go to IDLE; cdb_req, CDB and cdb_tag return to 0 after that edge.
  - No grant: hold indefinitely with values unchanged.
- Handshake rules:
  - start is ignored when ready=0; the reservation station must hold until it sees ready.
  - cdb_grant is ignored outside WAIT_CDB.
  - No accept happens in the same cycle as a grant; ready rises the cycle after the grant edge.
- Arithmetic: modulo 2^DW, wrap-around with no carry-out.
  - OP_ADD (3'b000): Vj+Vk.
  - OP_SUB (3'b001): Vj-Vk.
  - Any other opcode: result 0, still broadcast with its tag, so a dependent station never hangs.

Optional Feature:
- Macro: ASFU_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), valid with cdb_req.
  - ADD: 1 when both operands have the same sign and the result sign differs.
  - SUB: 1 when operand signs differ and the result sign differs from Vj.
  - 0 for illegal opcodes; 0 when cdb_req=0; 0 on reset.
- Undefined: no ovf port and no overflow logic.

Decomposition:
- Shared tomasulo_pkg holds:
  - Constants: DATA_W=16, TAG_W=3, OP_ADD, OP_SUB.
  - Typedef for the FU state enum.
  - Typedef cdb_t {tag, data}.
- One natural sub-module: asfu_alu, purely combinational.
  - Inputs: a, b, op.
  - Outputs: result, plus ovf under ASFU_OVF_EN.
- asfu keeps the FSM, counter and output registers.

Test Plan:
- LATENCY=2, start with Vj=5, Vk=3, OPcode=000, tag_in=2 at edge E0 -> cdb_req=1 after E2 with CDB=8, cdb_tag=2; grant at E3 -> ready=1, CDB=0 after E3.
- SUB wrap: Vj=0x0003, Vk=0x0005, OPcode=001 -> CDB=0xFFFE; with ASFU_OVF_EN, ovf=0.
- Grant held low 5 cycles -> cdb_req, CDB and cdb_tag stay stable; start pulses during this time are ignored with ready=0.
- Illegal OPcode=111, tag 4 -> broadcast CDB=0, cdb_tag=4, grant completes normally.
- CLR asserted mid-EXEC -> immediately busy=0, ready=1, cdb_req=0; no broadcast follows.
- ASFU_OVF_EN: ADD 0x7FFF+0x0001 -> CDB=0x8000, ovf=1; SUB 0x8000-0x0001 -> CDB=0x7FFF, ovf=1.
